// File: rtl/imem_pkg.sv
// Shared sizes, FSM states and word type for the instruction memory loader.
// No logic; no latency; no backpressure.
// Word type uses ascending bit order so bit 0 is the MSB of an instruction.
package imem_pkg;

    localparam int IMEM_ADDR_W = 4;
    localparam int IMEM_DEPTH  = 16;
    localparam int IMEM_WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        CHK,
        DONE
    } imem_state_t;

    typedef logic [0:IMEM_WORD_W-1] imem_word_t;

endpackage

// File: rtl/byte_packer.sv
// Packs bytes big-endian into a word: byte k lands in bits [8k:8k+7].
// Latency: word/word_complete are combinational with the final byte's push.
// Backpressure: none internally; the caller only pushes on an accepted byte.
module byte_packer
    import imem_pkg::*;
#(
    parameter int WORD_W = IMEM_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [7:0]        byte_in,
    output logic [0:WORD_W-1] word,
    output logic              word_complete
);

    localparam int BYTES = WORD_W / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    logic [CW-1:0]       cnt;
    logic [0:WORD_W-1]   acc;

    // The word already includes the byte being pushed, so the caller can
    // capture a complete word on the same edge the last byte is accepted.
    always_comb begin
        word = acc;
        word[{cnt, 3'b000} +: 8] = byte_in;
    end

    assign word_complete = push && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (clr) begin
            cnt <= '0;
            acc <= '0;
        end else if (push) begin
            acc <= word;
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Fills the instruction memory from a byte stream, one write per 4 bytes at addresses 0..DEPTH-1.
// Latency: wr_en one cycle after the 4th byte of a word; at most 1 word per 5 cycles.
// Backpressure: in_ready drops outside LOAD/CHK. IMEM_LOADER_CHECKSUM_EN adds an XOR check word and err.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int WORD_W = IMEM_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [0:WORD_W-1] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    imem_state_t         state, state_n;
    logic [ADDR_W-1:0]   word_cnt;
    logic                accept;
    logic                begin_s;
    logic                last_word;
    logic                pk_complete;
    logic [0:WORD_W-1]   pk_word;

    assign accept    = in_valid && in_ready;
    assign begin_s   = start && ((state == IDLE) || (state == DONE));
    assign last_word = (word_cnt == LAST_ADDR);

    byte_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (begin_s),
        .push          (accept),
        .byte_in       (in_data),
        .word          (pk_word),
        .word_complete (pk_complete)
    );

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (pk_complete) state_n = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_n = CHK;
`else
                    state_n = DONE;
`endif
                end else begin
                    state_n = LOAD;
                end
            end
            CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (pk_complete) state_n = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_n = LOAD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Advancing only in WRITE keeps the counter parked on DEPTH-1 at session end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (begin_s) begin
            word_cnt <= '0;
        end else if ((state == WRITE) && !last_word) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    // Captured once per word so the write port holds steady between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if ((state == LOAD) && pk_complete) begin
            wr_addr <= word_cnt;
            wr_data <= pk_word;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [0:WORD_W-1] xor_acc;
    logic              err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_acc <= '0;
            err_q   <= 1'b0;
        end else if (begin_s) begin
            xor_acc <= '0;
            err_q   <= 1'b0;
        end else if (pk_complete) begin
            if (state == LOAD) xor_acc <= xor_acc ^ pk_word;
            if (state == CHK)  err_q   <= (pk_word != xor_acc);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams with gaps, restarts and resets,
// checked against a word-level reference model and a captured instruction memory.
module tb_imem_loader;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [0:31] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    int          tests = 0;
    int          errors = 0;
    logic [31:0] words [DEPTH];
    logic [31:0] mem   [DEPTH];
    logic [31:0] exp_q [$];
    int          exp_addr = 0;
    int          wr_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction memory model plus in-order expectation of every write.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'd1, 64'd0);
            end else begin
                check("wr_addr", 64'(wr_addr), 64'(exp_addr));
                check("wr_data", 64'(wr_data), 64'(exp_q[0]));
                mem[wr_addr] = wr_data;
                void'(exp_q.pop_front());
                exp_addr++;
            end
        end
    end

    task automatic session(input int gap_pct, input int restart_at, input int abort_at, input bit chk_flip);
        logic [7:0]  bq [$];
        logic [31:0] x;
        int          idx, cyc, limit, nwords;
        bit          pending, rs_done;
        x = 32'h0;
        for (int w = 0; w < DEPTH; w++) begin
            x ^= words[w];
            for (int b = 0; b < 4; b++) bq.push_back(words[w][31-8*b -: 8]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = x ^ {31'b0, chk_flip};
        for (int b = 0; b < 4; b++) bq.push_back(x[31-8*b -: 8]);
`endif
        limit  = (abort_at >= 0) ? abort_at : bq.size();
        nwords = (abort_at >= 0) ? abort_at / 4 : DEPTH;
        exp_q = {};
        for (int w = 0; w < nwords; w++) exp_q.push_back(words[w]);
        exp_addr = 0;
        wr_seen  = 0;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_cleared", 64'(done), 64'd0);
        check("err_after_start", 64'(err), 64'd0);

        idx = 0; cyc = 0; pending = 0; rs_done = 0;
        while (idx < limit && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                check("wr_latency", 64'(wr_en), 64'd1);
                check("rdy_in_write", 64'(in_ready), 64'd0);
                pending = 0;
            end
            start = (restart_at >= 0 && idx == restart_at && !rs_done);
            if (start) rs_done = 1;
            in_valid = wr_en || ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? bq[idx] : 8'($urandom);
            if (in_valid && in_ready) begin
                if (idx % 4 == 3 && idx < 4 * DEPTH) pending = 1;
                idx++;
            end
        end
        if (idx < limit) check("stream_timeout", 64'(idx), 64'(limit));
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        if (pending) check("wr_latency_last", 64'(wr_en), 64'd1);

        if (abort_at >= 0) begin
            check("abort_writes", 64'(wr_seen), 64'(nwords));
            rst_n = 1'b0;
            #1;
            check("abort_outs_zero", {in_ready, wr_en, busy, done, err, wr_addr, wr_data}, 64'd0);
            repeat (4) @(negedge clk);
            check("abort_no_write", 64'(wr_seen), 64'(nwords));
            rst_n = 1'b1;
        end else begin
            cyc = 0;
            while (!done && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            check("done", 64'(done), 64'd1);
            check("busy_at_done", 64'(busy), 64'd0);
            check("wr_count", 64'(wr_seen), 64'(DEPTH));
            check("exp_drained", 64'(exp_q.size()), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
            check("chk_err", 64'(err), 64'(chk_flip));
`else
            check("err_tied", 64'(err), 64'd0);
`endif
            in_valid = 1'b1;
            in_data  = 8'h5A;
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
            check("done_sticky", 64'(done), 64'd1);
            check("done_no_ready", 64'(in_ready), 64'd0);
            for (int a = 0; a < DEPTH; a++) check("readback", 64'(mem[a]), 64'(words[a]));
        end
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #4;
        check("reset_outs", {in_ready, wr_en, busy, done, err, wr_addr, wr_data}, 64'd0);
        #10 rst_n = 1'b1;

        // Bytes presented while idle must be ignored.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (4) begin
            @(negedge clk);
            check("idle_no_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check("idle_no_write", 64'(wr_seen), 64'd0);

        for (int n = 0; n < DEPTH; n++) words[n] = 32'(n) * 32'h0101_0101;
        session(0, -1, -1, 1'b0);

        words[0] = 32'h1234_5678;
        for (int n = 1; n < DEPTH; n++) words[n] = $urandom;
        session(30, 5, -1, 1'b0);
        check("byte_order", 64'(mem[0]), 64'h1234_5678);

        for (int n = 0; n < DEPTH; n++) words[n] = $urandom;
        session(40, -1, 10, 1'b0);

        for (int n = 0; n < DEPTH; n++) words[n] = $urandom;
        session(20, -1, -1, 1'b0);
        session(50, -1, -1, 1'b1);
        session(10, 2, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
